// File: rtl/avalon_st_packetizer.sv
// Avalon-ST transmit framer: turns a byte-length command plus an unframed word stream
// into sop/eop/empty-delimited packets through a single registered output stage.
module avalon_st_packetizer #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int LEN_WIDTH           = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [LEN_WIDTH-1:0]                 cmd_len,
    input  logic [DATA_WIDTH_IN_BYTES*8-1:0]     src_data,
    input  logic                                 src_valid,
    output logic                                 src_ready,
    output logic [DATA_WIDTH_IN_BYTES*8-1:0]     framed_msg_data,
    output logic                                 framed_msg_valid,
    output logic                                 framed_msg_sop,
    output logic                                 framed_msg_eop,
    output logic [$clog2(DATA_WIDTH_IN_BYTES)-1:0] framed_msg_empty,
    input  logic                                 framed_msg_ready,
    output logic                                 busy,
    output logic                                 zero_len_error
);

    localparam int EW = $clog2(DATA_WIDTH_IN_BYTES);
    localparam logic [LEN_WIDTH:0] ROUND_UP = (LEN_WIDTH+1)'(DATA_WIDTH_IN_BYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                 state_reg;
    logic [LEN_WIDTH-1:0]   words_left_reg;
    logic [EW-1:0]          last_empty_reg;
    logic                   first_reg;

    logic [LEN_WIDTH:0]     len_round_up;
    logic [LEN_WIDTH-1:0]   cmd_words;
    logic [EW-1:0]          cmd_empty;
    logic                   src_fire;
    logic                   out_pop;
    logic                   last_word;

    // One extra bit so the round-up cannot wrap for lengths near the field maximum.
    assign len_round_up = {1'b0, cmd_len} + ROUND_UP;
    assign cmd_words    = LEN_WIDTH'(len_round_up >> EW);
    assign cmd_empty    = '0 - cmd_len[EW-1:0];

    assign cmd_ready = (state_reg == IDLE);
    assign busy      = (state_reg == SEND);
    assign src_ready = busy & (~framed_msg_valid | framed_msg_ready);
    assign src_fire  = src_valid & src_ready;
    assign out_pop   = framed_msg_valid & framed_msg_ready;
    assign last_word = (words_left_reg == LEN_WIDTH'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= IDLE;
            words_left_reg   <= '0;
            last_empty_reg   <= '0;
            first_reg        <= 1'b0;
            framed_msg_valid <= 1'b0;
            framed_msg_sop   <= 1'b0;
            framed_msg_eop   <= 1'b0;
            framed_msg_empty <= '0;
            framed_msg_data  <= '0;
            zero_len_error   <= 1'b0;
        end else begin
            zero_len_error <= 1'b0;

            // A pop without a refill empties the stage; a refill below overrides this.
            if (out_pop && !src_fire) begin
                framed_msg_valid <= 1'b0;
                framed_msg_sop   <= 1'b0;
                framed_msg_eop   <= 1'b0;
                framed_msg_empty <= '0;
                framed_msg_data  <= '0;
            end

            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_len != '0) begin
                            words_left_reg <= cmd_words;
                            last_empty_reg <= cmd_empty;
                            first_reg      <= 1'b1;
                            state_reg      <= SEND;
                        end else begin
                            zero_len_error <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (src_fire) begin
                        framed_msg_valid <= 1'b1;
                        framed_msg_data  <= src_data;
                        framed_msg_sop   <= first_reg;
                        framed_msg_eop   <= last_word;
                        framed_msg_empty <= last_word ? last_empty_reg : '0;
                        first_reg        <= 1'b0;
                        words_left_reg   <= words_left_reg - LEN_WIDTH'(1);
                        if (last_word) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
